rcc_reg_slv: RTL and testbench

RCC_REG_SLV -- requirements
Module: rcc_reg_slv

---
 rtl/rcc_reg_slv_if.sv | 32 +++
 rtl/rcc_reg_slv.sv | 160 ++++++++++++++++
 tb/tb_rcc_reg_slv.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rcc_reg_slv_if.sv
`default_nettype none
// ============================================================================
// Module   : rcc_reg_slv_if
// Brief    : Request/response bus between a master and the RCC register slave.
// Revision : 1.0 - initial release
// ============================================================================
interface rcc_reg_slv_if #(
    parameter int DW = 64,
    parameter int AW = 15,
    parameter int WW = DW / 8
) ();
    logic          mreq;
    logic          mwrite;
    logic [AW-1:0] maddr;
    logic [WW-1:0] mwstrb;
    logic [DW-1:0] mdata;
    logic          mmaster;
    logic [DW-1:0] sdata;
    logic          sready;
    logic          sresp;

    modport master (
        output mreq, mwrite, maddr, mwstrb, mdata, mmaster,
        input  sdata, sready, sresp
    );

    modport slave (
        input  mreq, mwrite, maddr, mwstrb, mdata, mmaster,
        output sdata, sready, sresp
    );
endinterface
`default_nettype wire

// File: rtl/rcc_reg_slv.sv
`default_nettype none
// ============================================================================
// Module   : rcc_reg_slv
// Brief    : Reset/clock-control register slave with wait states; optional
//            CLKEN/RSTCTL write protection enabled by macro RCC_WPROT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rcc_reg_slv #(
    parameter int DW   = 64,
    parameter int AW   = 15,
    parameter int WW   = DW / 8,
    parameter int WAIT = 1
) (
    input  wire          hclk,
    input  wire          hresetn,
    rcc_reg_slv_if.slave bus,
    output logic [31:0]  clk_en,
    output logic [31:0]  blk_rst_n,
    input  wire  [31:0]  status_i
);
    localparam logic [AW-1:0] c_addr_ctrl   = AW'(0);
    localparam logic [AW-1:0] c_addr_clken  = AW'(1);
    localparam logic [AW-1:0] c_addr_rstctl = AW'(2);
    localparam logic [AW-1:0] c_addr_status = AW'(3);
    localparam logic [1:0]    c_wait        = 2'(WAIT);

    logic [31:0]   ctrl_q, ctrl_d, clken_q, clken_d, rstctl_q, rstctl_d;
    logic          lastm_q, lastm_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          w_ready, w_done, w_err, w_wr, w_act, w_mapped, w_prot_block;
    logic          w_is_ctrl, w_is_clken, w_is_rstctl, w_is_status;
    logic [1:0]    w_lock_bits;
    logic [63:0]   w_status;
    logic [DW-1:0] w_rdata;
    logic          w_unused_bits;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] wd,
                                            input logic [3:0]  be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = be[k] ? wd[8*k +: 8] : old_v[8*k +: 8];
        end
        return r;
    endfunction

    assign w_is_ctrl   = (bus.maddr == c_addr_ctrl);
    assign w_is_clken  = (bus.maddr == c_addr_clken);
    assign w_is_rstctl = (bus.maddr == c_addr_rstctl);
    assign w_is_status = (bus.maddr == c_addr_status);

    // Reset forces ready high so a held mreq cannot stall the bus
    assign w_ready = ~hresetn | ~bus.mreq | (cnt_q == c_wait);
    assign w_done  = bus.mreq & w_ready;
    assign w_err   = ~w_mapped | (bus.mwrite & w_is_status) | w_prot_block;
    // A zero-strobe write is a no-op for every piece of state
    assign w_act   = w_done & ~w_err & (~bus.mwrite | (|bus.mwstrb));
    assign w_wr    = w_act & bus.mwrite;

`ifdef RCC_WPROT_EN
    typedef enum logic [1:0] {
        LOCKED   = 2'b00,
        KEY1     = 2'b01,
        UNLOCKED = 2'b10
    } lock_t;

    localparam logic [AW-1:0] c_addr_wpkey = AW'(4);

    lock_t lock_q, lock_d;
    logic  w_is_wpkey;

    assign w_is_wpkey   = (bus.maddr == c_addr_wpkey);
    assign w_mapped     = w_is_ctrl | w_is_clken | w_is_rstctl | w_is_status | w_is_wpkey;
    assign w_prot_block = bus.mwrite & (w_is_clken | w_is_rstctl) & (lock_q != UNLOCKED);
    assign w_lock_bits  = lock_q;

    always_comb begin
        lock_d = lock_q;
        if (w_wr && w_is_wpkey) begin
            case (lock_q)
                LOCKED:  lock_d = (bus.mdata[7:0] == 8'hCA) ? KEY1 : LOCKED;
                KEY1:    lock_d = (bus.mdata[7:0] == 8'h53) ? UNLOCKED : LOCKED;
                default: lock_d = LOCKED;
            endcase
        end else if (w_act && !w_is_wpkey && lock_q == KEY1) begin
            lock_d = LOCKED;
        end else if (w_wr && (w_is_clken || w_is_rstctl) && lock_q == UNLOCKED) begin
            lock_d = LOCKED;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lock_q <= LOCKED;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign w_mapped     = w_is_ctrl | w_is_clken | w_is_rstctl | w_is_status;
    assign w_prot_block = 1'b0;
    assign w_lock_bits  = 2'b00;
`endif

    always_comb begin
        ctrl_d   = ctrl_q;
        clken_d  = clken_q;
        rstctl_d = rstctl_q;
        lastm_d  = lastm_q;
        cnt_d    = cnt_q;
        if (w_done) begin
            cnt_d = 2'd0;
        end else if (bus.mreq && cnt_q < c_wait) begin
            cnt_d = cnt_q + 2'd1;
        end
        if (w_wr) begin
            lastm_d = bus.mmaster;
            if (w_is_ctrl)   ctrl_d   = f_merge(ctrl_q,   bus.mdata[31:0], bus.mwstrb[3:0]);
            if (w_is_clken)  clken_d  = f_merge(clken_q,  bus.mdata[31:0], bus.mwstrb[3:0]);
            if (w_is_rstctl) rstctl_d = f_merge(rstctl_q, bus.mdata[31:0], bus.mwstrb[3:0]);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ctrl_q   <= 32'h0000_0001;
            clken_q  <= 32'h0000_0000;
            rstctl_q <= 32'hFFFF_FFFF;
            lastm_q  <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ctrl_q   <= ctrl_d;
            clken_q  <= clken_d;
            rstctl_q <= rstctl_d;
            lastm_q  <= lastm_d;
            cnt_q    <= cnt_d;
        end
    end

    // lastm sits in the MSB of the 64-bit word, lock state just above status_i
    assign w_status = {lastm_q, 29'b0, w_lock_bits, status_i};

    always_comb begin
        w_rdata = '0;
        if (bus.mreq) begin
            if (w_is_ctrl)   w_rdata = DW'(ctrl_q);
            if (w_is_clken)  w_rdata = DW'(clken_q);
            if (w_is_rstctl) w_rdata = DW'(rstctl_q);
            if (w_is_status) w_rdata = DW'(w_status);
        end
    end

    assign bus.sdata     = w_rdata;
    assign bus.sready    = w_ready;
    assign bus.sresp     = hresetn & w_done & w_err;
    assign clk_en        = clken_q;
    assign blk_rst_n     = ~rstctl_q;
    assign w_unused_bits = ^bus.mdata[DW-1:32];
endmodule
`default_nettype wire

// File: tb/tb_rcc_reg_slv.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcc_reg_slv
// Brief    : Directed self-checking bench for rcc_reg_slv (DW=64, WAIT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rcc_reg_slv;
    localparam int DW   = 64;
    localparam int AW   = 15;
    localparam int WW   = 8;
    localparam int WAIT = 1;

    logic        hclk;
    logic        hresetn;
    logic [31:0] clk_en;
    logic [31:0] blk_rst_n;
    logic [31:0] status_i;
    int          n_chk;
    int          n_pass;
    logic [63:0] rd;
    logic        rsp;

    rcc_reg_slv_if #(.DW(DW), .AW(AW), .WW(WW)) bus_if ();

    rcc_reg_slv #(.DW(DW), .AW(AW), .WW(WW), .WAIT(WAIT)) u_dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .bus       (bus_if.slave),
        .clk_en    (clk_en),
        .blk_rst_n (blk_rst_n),
        .status_i  (status_i)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input logic wr, input logic [14:0] addr,
                          input logic [7:0] strb, input logic [63:0] data, input logic mm,
                          output logic [63:0] rdat, output logic resp);
        int waits;
        @(negedge hclk);
        bus_if.mreq    = 1'b1;
        bus_if.mwrite  = wr;
        bus_if.maddr   = addr;
        bus_if.mwstrb  = strb;
        bus_if.mdata   = data;
        bus_if.mmaster = mm;
        #1;
        waits = 0;
        while (bus_if.sready !== 1'b1 && waits < 8) begin
            @(negedge hclk);
            #1;
            waits++;
        end
        chk({tag, "_wait"}, 64'(waits), 64'(WAIT));
        rdat = bus_if.sdata;
        resp = bus_if.sresp;
    endtask

    task automatic idle();
        @(negedge hclk);
        bus_if.mreq   = 1'b0;
        bus_if.mwrite = 1'b0;
        bus_if.mwstrb = '0;
        bus_if.mdata  = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [14:0] addr, input logic [63:0] exp);
        logic [63:0] d;
        logic        r;
        access(tag, 1'b0, addr, 8'h00, 64'h0, 1'b0, d, r);
        chk(tag, d, exp);
        chk({tag, "_resp"}, 64'(r), 64'(1'b0));
    endtask

    task automatic wr_chk(input string tag, input logic [14:0] addr, input logic [7:0] strb,
                          input logic [63:0] data, input logic mm, input logic exp_resp);
        logic [63:0] d;
        logic        r;
        access(tag, 1'b1, addr, strb, data, mm, d, r);
        chk({tag, "_resp"}, 64'(r), 64'(exp_resp));
    endtask

`ifdef RCC_WPROT_EN
    task automatic unlock(input string tag);
        wr_chk({tag, "_key1"}, 15'd4, 8'hFF, 64'hCA, 1'b0, 1'b0);
        wr_chk({tag, "_key2"}, 15'd4, 8'hFF, 64'h53, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        hresetn        = 1'b0;
        status_i       = 32'hDEAD_BEEF;
        bus_if.mreq    = 1'b1;
        bus_if.mwrite  = 1'b0;
        bus_if.maddr   = 15'd2;
        bus_if.mwstrb  = '0;
        bus_if.mdata   = '0;
        bus_if.mmaster = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_sready", 64'(bus_if.sready), 64'(1'b1));
        chk("rst_sresp", 64'(bus_if.sresp), 64'(1'b0));
        chk("rst_clk_en", 64'(clk_en), 64'h0);
        chk("rst_blk_rst_n", 64'(blk_rst_n), 64'h0);
        @(negedge hclk);
        bus_if.mreq = 1'b0;
        hresetn     = 1'b1;

        rd_chk("rd_rstctl", 15'd2, 64'h0000_0000_FFFF_FFFF);
        chk("rd_rstctl_blk", 64'(blk_rst_n), 64'h0);
        idle();
        rd_chk("rd_ctrl_rst", 15'd0, 64'h1);
        rd_chk("rd_status_rst", 15'd3, 64'h0000_0000_DEAD_BEEF);
        idle();

        wr_chk("wr_ctrl", 15'd0, 8'h03, 64'h1234_5678, 1'b0, 1'b0);
        idle();
        rd_chk("rd_ctrl", 15'd0, 64'h0000_0000_0000_5678);
        idle();

`ifdef RCC_WPROT_EN
        wr_chk("wr_clken_locked", 15'd1, 8'hFF, 64'hF, 1'b0, 1'b1);
        idle();
        chk("clk_en_locked", 64'(clk_en), 64'h0);
        unlock("ul1");
`endif
        wr_chk("b2b_wr_clken", 15'd1, 8'hFF, 64'hFFFF_FFFF_0000_000F, 1'b1, 1'b0);
        chk("clk_en_before", 64'(clk_en), 64'h0);
        rd_chk("b2b_rd_clken", 15'd1, 64'h0000_0000_0000_000F);
        chk("clk_en_after", 64'(clk_en), 64'hF);
        idle();

        access("rd_unmapped", 1'b0, 15'd7, 8'h00, 64'h0, 1'b0, rd, rsp);
        chk("rd_unmapped_resp", 64'(rsp), 64'(1'b1));
        chk("rd_unmapped_data", rd, 64'h0);
        idle();
        #1;
        chk("unmapped_resp_one_cycle", 64'(bus_if.sresp), 64'(1'b0));
        rd_chk("rd_ctrl_after_err", 15'd0, 64'h0000_0000_0000_5678);
        idle();

        wr_chk("wr_status", 15'd3, 8'hFF, 64'h0, 1'b0, 1'b1);
        idle();
        wr_chk("wr_ctrl_zero_strb", 15'd0, 8'h00, 64'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        rd_chk("rd_ctrl_zero_strb", 15'd0, 64'h0000_0000_0000_5678);
        idle();

`ifdef RCC_WPROT_EN
        unlock("ul2");
`endif
        wr_chk("wr_rstctl", 15'd2, 8'hFF, 64'hFFFF_FFFF_0000_00FF, 1'b1, 1'b0);
        idle();
        chk("blk_rst_n_wr", 64'(blk_rst_n), 64'hFFFF_FF00);
        rd_chk("rd_rstctl_wr", 15'd2, 64'h0000_0000_0000_00FF);
        rd_chk("rd_status_lastm", 15'd3, 64'h8000_0000_DEAD_BEEF);
        idle();

`ifdef RCC_WPROT_EN
        wr_chk("key1_a", 15'd4, 8'hFF, 64'hCA, 1'b0, 1'b0);
        rd_chk("rd_status_key1", 15'd3, 64'h0000_0001_DEAD_BEEF);
        wr_chk("wr_clken_relock", 15'd1, 8'hFF, 64'h33, 1'b0, 1'b1);
        wr_chk("key1_b", 15'd4, 8'hFF, 64'hCA, 1'b0, 1'b0);
        rd_chk("rd_ctrl_in_key1", 15'd0, 64'h0000_0000_0000_5678);
        wr_chk("key2_late", 15'd4, 8'hFF, 64'h53, 1'b0, 1'b0);
        wr_chk("wr_clken_still_locked", 15'd1, 8'hFF, 64'h33, 1'b0, 1'b1);
        idle();
        chk("clk_en_kept", 64'(clk_en), 64'hF);
        unlock("ul3");
`else
        wr_chk("wr_wpkey_unmapped", 15'd4, 8'hFF, 64'hCA, 1'b0, 1'b1);
        idle();
`endif

        @(negedge hclk);
        bus_if.mreq    = 1'b1;
        bus_if.mwrite  = 1'b1;
        bus_if.maddr   = 15'd1;
        bus_if.mwstrb  = 8'hFF;
        bus_if.mdata   = 64'hFF;
        bus_if.mmaster = 1'b1;
        #1;
        chk("midwait_sready", 64'(bus_if.sready), 64'(1'b0));
        #2;
        hresetn = 1'b0;
        #1;
        chk("midrst_sready", 64'(bus_if.sready), 64'(1'b1));
        chk("midrst_sresp", 64'(bus_if.sresp), 64'(1'b0));
        chk("midrst_clk_en", 64'(clk_en), 64'h0);
        chk("midrst_blk_rst_n", 64'(blk_rst_n), 64'h0);
        @(posedge hclk);
        @(negedge hclk);
        bus_if.mreq   = 1'b0;
        bus_if.mwrite = 1'b0;
        hresetn       = 1'b1;
        rd_chk("post_rst_clken", 15'd1, 64'h0);
        rd_chk("post_rst_ctrl", 15'd0, 64'h1);
        rd_chk("post_rst_rstctl", 15'd2, 64'h0000_0000_FFFF_FFFF);
        rd_chk("post_rst_status", 15'd3, 64'h0000_0000_DEAD_BEEF);
        idle();
`ifdef RCC_WPROT_EN
        wr_chk("post_rst_locked", 15'd1, 8'hFF, 64'h1, 1'b0, 1'b1);
        idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
